// File: rtl/core_dma_cmd_issuer.sv
// DMA command issuer: one request becomes a beat-level write or read stream.
// Optional ISSUER_STATS_EN macro builds the beat statistics counters.
module core_dma_cmd_issuer #(
  parameter int DATA_WIDTH      = 128,
  parameter int STRB_WIDTH      = DATA_WIDTH / 8,
  parameter int LEN_WIDTH       = 16,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_dir,
  input  logic [25:0]           req_addr,
  input  logic                  req_hdr_en,
  input  logic [23:0]           req_hdr_addr,
  input  logic [LEN_WIDTH-1:0]  req_len,
  input  logic [DATA_WIDTH-1:0] s_wr_data,
  input  logic                  s_wr_valid,
  output logic                  s_wr_ready,
  output logic                  dma_cmd_wr_en,
  output logic [25:0]           dma_cmd_wr_addr,
  output logic                  dma_cmd_hdr_wr_en,
  output logic [23:0]           dma_cmd_hdr_wr_addr,
  output logic [DATA_WIDTH-1:0] dma_cmd_wr_data,
  output logic [STRB_WIDTH-1:0] dma_cmd_wr_strb,
  output logic                  dma_cmd_wr_last,
  input  logic                  dma_cmd_wr_ready,
  output logic                  dma_cmd_rd_en,
  output logic [25:0]           dma_cmd_rd_addr,
  output logic                  dma_cmd_rd_last,
  input  logic                  dma_cmd_rd_ready,
  input  logic                  dma_rd_resp_valid,
  input  logic [DATA_WIDTH-1:0] dma_rd_resp_data,
  output logic                  dma_rd_resp_ready,
  output logic [DATA_WIDTH-1:0] m_rd_data,
  output logic [STRB_WIDTH-1:0] m_rd_keep,
  output logic                  m_rd_last,
  output logic                  m_rd_valid,
  input  logic                  m_rd_ready,
  output logic                  done_valid,
  output logic                  done_dir,
  output logic                  busy,
  output logic [31:0]           stat_wr_beats,
  output logic [31:0]           stat_rd_beats
);

  localparam int SHIFT = $clog2(STRB_WIDTH);
  localparam int CW    = LEN_WIDTH - SHIFT + 1;
  localparam int OW    = $clog2(MAX_OUTSTANDING) + 1;

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic                  dir_q;
  logic                  hdr_en_q;
  logic [25:0]           base_q;
  logic [23:0]           hbase_q;
  logic [CW-1:0]         n_q;
  logic [STRB_WIDTH-1:0] tail_q;
  logic [CW-1:0]         beat_q;
  logic [CW-1:0]         resp_q;
  logic [OW-1:0]         out_q;

  logic [SHIFT-1:0]      rem;
  logic [CW-1:0]         n_req;
  logic [STRB_WIDTH-1:0] tail_req;
  logic [25:0]           beat_off;
  logic                  beat_last;
  logic                  resp_last;
  logic                  req_acc;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  resp_acc;
  logic                  unused_low;

  assign unused_low = ^{req_addr[SHIFT-1:0],
                        req_hdr_addr[SHIFT-1:0]};

  assign rem      = req_len[SHIFT-1:0];
  assign n_req    = CW'(req_len[LEN_WIDTH-1:SHIFT])
                  + CW'(rem != '0);
  assign tail_req = (rem == '0) ? '1
                  : ~({STRB_WIDTH{1'b1}} << rem);

  assign beat_off  = 26'({beat_q, {SHIFT{1'b0}}});
  assign beat_last = (beat_q == n_q - CW'(1));
  assign resp_last = (resp_q == n_q - CW'(1));

  assign dma_cmd_wr_addr     = base_q + beat_off;
  assign dma_cmd_hdr_wr_addr = hbase_q + beat_off[23:0];
  assign dma_cmd_rd_addr     = base_q + beat_off;
  assign dma_cmd_wr_data     = s_wr_data;
  assign dma_cmd_wr_strb     = beat_last ? tail_q : '1;
  assign m_rd_data           = dma_rd_resp_data;
  assign m_rd_keep           = resp_last ? tail_q : '1;
  assign done_dir            = dir_q;
  assign busy                = (state_q != IDLE);

  assign req_acc  = req_valid & req_ready;
  assign wr_acc   = dma_cmd_wr_en & dma_cmd_wr_ready;
  assign rd_acc   = dma_cmd_rd_en & dma_cmd_rd_ready;
  assign resp_acc = m_rd_valid & m_rd_ready;

  // Next-state and stream handshake decode
  always_comb begin
    state_d           = state_q;
    req_ready         = 1'b0;
    s_wr_ready        = 1'b0;
    dma_cmd_wr_en     = 1'b0;
    dma_cmd_hdr_wr_en = 1'b0;
    dma_cmd_wr_last   = 1'b0;
    dma_cmd_rd_en     = 1'b0;
    dma_cmd_rd_last   = 1'b0;
    dma_rd_resp_ready = 1'b0;
    m_rd_valid        = 1'b0;
    m_rd_last         = 1'b0;
    done_valid        = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = rst_n;
        if (req_valid) begin
          if (req_len == '0)
            state_d = DONE;
          else if (req_dir)
            state_d = RD;
          else
            state_d = WR;
        end
      end
      WR: begin
        dma_cmd_wr_en     = s_wr_valid;
        s_wr_ready        = dma_cmd_wr_ready;
        dma_cmd_hdr_wr_en = s_wr_valid & hdr_en_q;
        dma_cmd_wr_last   = beat_last;
        if (s_wr_valid && dma_cmd_wr_ready && beat_last)
          state_d = DONE;
      end
      RD: begin
        dma_cmd_rd_en     = (beat_q < n_q)
                          && (out_q < OW'(MAX_OUTSTANDING));
        dma_cmd_rd_last   = beat_last;
        m_rd_valid        = dma_rd_resp_valid;
        dma_rd_resp_ready = m_rd_ready;
        m_rd_last         = resp_last;
        if (dma_rd_resp_valid && m_rd_ready && resp_last)
          state_d = DONE;
      end
      DONE: begin
        done_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched request and beat counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      dir_q    <= 1'b0;
      hdr_en_q <= 1'b0;
      base_q   <= '0;
      hbase_q  <= '0;
      n_q      <= '0;
      tail_q   <= '0;
      beat_q   <= '0;
      resp_q   <= '0;
      out_q    <= '0;
    end else begin
      state_q <= state_d;
      if (req_acc) begin
        dir_q    <= req_dir;
        hdr_en_q <= req_hdr_en & ~req_dir;
        base_q   <= {req_addr[25:SHIFT], {SHIFT{1'b0}}};
        hbase_q  <= {req_hdr_addr[23:SHIFT], {SHIFT{1'b0}}};
        n_q      <= n_req;
        tail_q   <= tail_req;
        beat_q   <= '0;
        resp_q   <= '0;
        out_q    <= '0;
      end else begin
        if (wr_acc || rd_acc)
          beat_q <= beat_q + CW'(1);
        if (resp_acc)
          resp_q <= resp_q + CW'(1);
        if (rd_acc && !resp_acc)
          out_q <= out_q + OW'(1);
        else if (!rd_acc && resp_acc)
          out_q <= out_q - OW'(1);
      end
    end
  end

`ifdef ISSUER_STATS_EN
  logic [31:0] stat_wr_q;
  logic [31:0] stat_rd_q;

  // Accepted write beat and read response counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_wr_q <= '0;
      stat_rd_q <= '0;
    end else begin
      if (wr_acc)
        stat_wr_q <= stat_wr_q + 32'd1;
      if (resp_acc)
        stat_rd_q <= stat_rd_q + 32'd1;
    end
  end

  assign stat_wr_beats = stat_wr_q;
  assign stat_rd_beats = stat_rd_q;
`else
  assign stat_wr_beats = '0;
  assign stat_rd_beats = '0;
`endif

endmodule

// File: doc/core_dma_cmd_issuer.md
# core_dma_cmd_issuer

Initiator side of the per-core DMA command interface. It turns a single transfer request into a beat-level `dma_cmd_wr_*` write stream or `dma_cmd_rd_*` read-command stream toward a core's memory port. Read responses from `dma_rd_resp_*` are returned as a framed output stream. The block sits in the scheduler/DMA fabric, upstream of each core's pipe-registered DMA port, and signals completion per transfer.

## Interface
- `DATA_WIDTH`, 128, beat width in bits
- `STRB_WIDTH`, DATA_WIDTH/8, bytes per beat
- `LEN_WIDTH`, 16, request length field width, in bytes
- `MAX_OUTSTANDING`, 16, maximum read commands in flight; must be a power of 2, ≥2
- `clk` in 1: sole clock
- `rst_n` in 1: synchronous, active-low reset
- `req_valid` in 1 / `req_ready` out 1: request handshake
- `req_dir` in 1: 0 = write, 1 = read
- `req_addr` in 26: core memory byte address; low log2(STRB_WIDTH) bits are ignored
- `req_hdr_en` in 1 / `req_hdr_addr` in 24: also write each beat to the header region (writes only)
- `req_len` in LEN_WIDTH: length in bytes
- `s_wr_data` in DATA_WIDTH / `s_wr_valid` in 1 / `s_wr_ready` out 1: write payload beats
- `dma_cmd_wr_en` out 1, `dma_cmd_wr_addr` out 26, `dma_cmd_hdr_wr_en` out 1, `dma_cmd_hdr_wr_addr` out 24, `dma_cmd_wr_data` out DATA_WIDTH, `dma_cmd_wr_strb` out STRB_WIDTH, `dma_cmd_wr_last` out 1, `dma_cmd_wr_ready` in 1
- `dma_cmd_rd_en` out 1, `dma_cmd_rd_addr` out 26, `dma_cmd_rd_last` out 1, `dma_cmd_rd_ready` in 1
- `dma_rd_resp_valid` in 1, `dma_rd_resp_data` in DATA_WIDTH, `dma_rd_resp_ready` out 1
- `m_rd_data` out DATA_WIDTH, `m_rd_keep` out STRB_WIDTH, `m_rd_last` out 1, `m_rd_valid` out 1, `m_rd_ready` in 1
- `done_valid` out 1: one-cycle completion pulse; `done_dir` out 1: direction of the completed transfer
- `busy` out 1: state ≠ IDLE
- `stat_wr_beats` out 32, `stat_rd_beats` out 32: see Configuration

## Operation
- Beat count N = ceil(req_len / STRB_WIDTH).
- Tail mask: all ones if req_len % STRB_WIDTH = 0, else (1<<rem)−1. The tail mask applies to the final beat; all other beats use all ones.
- Beat address = aligned req_addr + STRB_WIDTH·k. The header address is formed the same way from req_hdr_addr. Both addresses wrap modulo their field width.
- FSM states: IDLE, WR, RD, DONE.
  - IDLE: `req_ready`=1. On accept, latch the request fields. req_len=0 goes directly to DONE. Otherwise go to WR or RD by req_dir.
  - WR: pass-through. `dma_cmd_wr_en` = `s_wr_valid` and `s_wr_ready` = `dma_cmd_wr_ready`; data is forwarded unchanged. `dma_cmd_hdr_wr_en` = `dma_cmd_wr_en` & hdr_en. `dma_cmd_wr_last` is set on beat N−1. The beat counter advances on valid&ready. Accepting the last beat moves to DONE.
  - RD: two independent counters.
    - Issue counter: `dma_cmd_rd_en` = (issued<N) & (outstanding<MAX_OUTSTANDING). `dma_cmd_rd_last` is set on command N−1.
    - Response counter: `m_rd_valid` = `dma_rd_resp_valid` and `dma_rd_resp_ready` = `m_rd_ready`, both combinational. `m_rd_keep` uses the tail mask and `m_rd_last` is set on response N−1.
    - Accepting the last response moves to DONE.
  - DONE: `done_valid`=1 for one cycle, `done_dir` = latched dir, then IDLE.
- Outstanding counter (log2(MAX_OUTSTANDING)+1 bits): +1 on command accept, −1 on response accept, unchanged when both occur in the same cycle.
- Outside their active state, all stream valids and readies are 0. In particular, responses arriving in IDLE are stalled, not dropped.

## Timing
- Reset values (rst_n=0 at a clk edge):
  - state IDLE; all counters 0.
  - All `*_en`, `*_valid`, `*_last`, `done_valid` and `busy` = 0; `req_ready` = 0 during reset.
  - Address and data outputs are don't-care.
  - Reset mid-transfer abandons the transfer with no `done_valid`. The responder must be reset together with this block.
- Request accept → first `dma_cmd_wr_en`/`dma_cmd_rd_en`: 1 cycle.
- Write path and response path are zero-latency, combinational valid/ready.
- Last beat accepted at cycle t → `done_valid` at t+1 → `req_ready` at t+2. Back-to-back request throughput is therefore N+2 cycles.
- Read commands sustain 1 per cycle until MAX_OUTSTANDING are in flight. With full outstanding and a simultaneous response accept, the next command issues in the following cycle.
- req_len=0: accept at t, `done_valid` at t+1, with no DMA activity.

## Configuration
- `ISSUER_STATS_EN` defined:
  - `stat_wr_beats` counts accepted write beats; `stat_rd_beats` counts accepted read responses.
  - Both are 32-bit, wrap at 2^32, and are cleared by reset only.
- Not defined: both outputs are tied to 0 and no counter logic is built.

## Test plan
- Write, addr 0x000104, len 40, hdr_en=1, hdr_addr 0x000020 → 3 beats at 0x100/0x110/0x120. Header addresses are 0x20/0x30/0x40. Strobes are 0xFFFF, 0xFFFF, 0x00FF. Last is set on beat 2, followed by one `done_valid` with dir=0.
- Read, len 512 (32 beats), MAX_OUTSTANDING=16, responder withholds responses → exactly 16 commands issue, then `dma_cmd_rd_en` stays 0. After the responses are released, all 32 `m_rd` beats arrive in order with `m_rd_last` on beat 31.
- Read, len 17, with `m_rd_ready` toggling every cycle → 2 beats. Keep values are 0xFFFF then 0x0001; `dma_rd_resp_ready` mirrors `m_rd_ready`; no beat is lost or duplicated.
- req_len=0, dir=1 → no commands; `done_valid` pulses 1 cycle after accept.
- rst_n low during a 10-beat write after beat 4 → outputs return to reset values. A new write of len 16 then yields 1 beat with last=1 and strb 0xFFFF.
- With `ISSUER_STATS_EN`: write 3 beats, then read 5 beats → `stat_wr_beats`=3, `stat_rd_beats`=5. Without the macro, both read 0.
